// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared constants for the machine-mode CSR file and trap sequencer
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_NOP = 2'b00,
        CSR_RW  = 2'b01,
        CSR_RS  = 2'b10,
        CSR_RC  = 2'b11
    } csr_op_e;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    localparam int CAUSE_M_TIMER = 7;
    localparam int CAUSE_M_EXT   = 11;

    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0880;

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with increment enable and split half writes
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        lo_we,
    input  logic        hi_we,
    input  logic [63:0] wdata,
    output logic [63:0] count
);

    // A write to either half wins over the increment for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (lo_we || hi_we) begin
            if (lo_we) count[31:0]  <= wdata[31:0];
            if (hi_we) count[63:32] <= wdata[63:32];
        end else if (inc_en) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file with trap entry, mret and interrupt gating
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit HAS_COUNTERS   = 1'b1,
    parameter bit MTVEC_VECTORED = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_csr_en,
    input  logic [1:0]      i_csr_op,
    input  logic [11:0]     i_csr_addr,
    input  logic [XLEN-1:0] i_csr_wsrc,
    input  logic            i_csr_wzero,
    output logic [XLEN-1:0] o_csr_rdata,
    output logic            o_csr_illegal,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_cause,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic            i_mret,
    input  logic            i_retire,
    input  logic            i_irq_timer,
    input  logic            i_irq_ext,
    output logic            o_irq_pending,
    output logic [XLEN-1:0] o_irq_cause,
    output logic [XLEN-1:0] o_trap_vec,
    output logic [XLEN-1:0] o_mepc
);

    localparam logic [XLEN-1:0] MTVEC_WMASK = MTVEC_VECTORED ? ~XLEN'(2) : ~XLEN'(3);
    localparam logic [XLEN-1:0] IRQ_MSB     = {1'b1, {(XLEN-1){1'b0}}};

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mie_reg;
    logic [63:0]     mcycle;
    logic [63:0]     minstret;

    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mip;
    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_off;
    logic [63:0]     wd_ext;
    logic [63:0]     cnt_wdata;
    csr_op_e         op;
    logic            addr_ok;
    logic            addr_ro;
    logic            active;
    logic            write_req;
    logic            illegal;
    logic            do_write;
    logic            cyc_lo_we;
    logic            cyc_hi_we;
    logic            ret_lo_we;
    logic            ret_hi_we;

    assign op = csr_op_e'(i_csr_op);

    always_comb begin
        mstatus = '0;
        mstatus[MSTATUS_MPP_LO +: 2] = 2'b11;
        mstatus[MSTATUS_MPIE]        = mstatus_mpie;
        mstatus[MSTATUS_MIE]         = mstatus_mie;
        mip = '0;
        mip[MIE_MTIE] = i_irq_timer;
        mip[MIE_MEIE] = i_irq_ext;
    end

    // Address decode and old-value read; misa and mhartid read as zero.
    always_comb begin
        addr_ok = 1'b1;
        addr_ro = 1'b0;
        rdata   = '0;
        case (i_csr_addr)
            ADDR_MSTATUS:  rdata = mstatus;
            ADDR_MISA:     addr_ro = 1'b1;
            ADDR_MIE:      rdata = mie_reg;
            ADDR_MTVEC:    rdata = mtvec;
            ADDR_MSCRATCH: rdata = mscratch;
            ADDR_MEPC:     rdata = mepc;
            ADDR_MCAUSE:   rdata = mcause;
            ADDR_MIP: begin
                rdata   = mip;
                addr_ro = 1'b1;
            end
            ADDR_MHARTID:  addr_ro = 1'b1;
            ADDR_MCYCLE: begin
                addr_ok = HAS_COUNTERS;
                rdata   = XLEN'(mcycle);
            end
            ADDR_MINSTRET: begin
                addr_ok = HAS_COUNTERS;
                rdata   = XLEN'(minstret);
            end
            ADDR_MCYCLEH: begin
                addr_ok = HAS_COUNTERS && (XLEN == 32);
                rdata   = XLEN'(mcycle[63:32]);
            end
            ADDR_MINSTRETH: begin
                addr_ok = HAS_COUNTERS && (XLEN == 32);
                rdata   = XLEN'(minstret[63:32]);
            end
            default:       addr_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            CSR_RW:  wdata = i_csr_wsrc;
            CSR_RS:  wdata = rdata | i_csr_wsrc;
            CSR_RC:  wdata = rdata & ~i_csr_wsrc;
            default: wdata = rdata;
        endcase
    end

    assign active    = i_csr_en && (op != CSR_NOP);
    assign write_req = active && ((op == CSR_RW) || !i_csr_wzero);
    assign illegal   = active && (!addr_ok || (addr_ro && write_req));
    // Trap and mret in the same cycle drop the CSR write entirely.
    assign do_write  = write_req && addr_ok && !addr_ro && !i_trap && !i_mret;

    assign o_csr_rdata   = (i_csr_en && addr_ok) ? rdata : '0;
    assign o_csr_illegal = illegal;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mtvec        <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mscratch     <= '0;
            mie_reg      <= '0;
        end else if (i_trap) begin
            mepc         <= i_trap_pc & ~XLEN'(3);
            mcause       <= i_trap_cause;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (i_mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (do_write) begin
            case (i_csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie  <= wdata[MSTATUS_MIE] & MSTATUS_WMASK[MSTATUS_MIE];
                    mstatus_mpie <= wdata[MSTATUS_MPIE] & MSTATUS_WMASK[MSTATUS_MPIE];
                end
                ADDR_MIE:      mie_reg  <= wdata & XLEN'(MIE_WMASK);
                ADDR_MTVEC:    mtvec    <= wdata & MTVEC_WMASK;
                ADDR_MSCRATCH: mscratch <= wdata;
                ADDR_MEPC:     mepc     <= wdata & ~XLEN'(3);
                ADDR_MCAUSE:   mcause   <= wdata;
                default:       ;
            endcase
        end
    end

    // Vectored offset is 4*cause with the interrupt flag dropped.
    assign vec_base   = {mtvec[XLEN-1:2], 2'b00};
    assign vec_off    = {i_trap_cause[XLEN-3:0], 2'b00};
    assign o_trap_vec = (mtvec[0] && i_trap_cause[XLEN-1]) ? vec_base + vec_off : vec_base;
    assign o_mepc     = mepc;

    assign pend          = mip & mie_reg;
    assign o_irq_pending = mstatus_mie && (|pend);

    always_comb begin
        if (!o_irq_pending)
            o_irq_cause = '0;
        else if (pend[MIE_MEIE])
            o_irq_cause = IRQ_MSB | XLEN'(CAUSE_M_EXT);
        else
            o_irq_cause = IRQ_MSB | XLEN'(CAUSE_M_TIMER);
    end

    // On RV32 each half is written separately; on RV64 one write covers both halves.
    assign wd_ext    = 64'(wdata);
    assign cnt_wdata = (XLEN == 32) ? {wd_ext[31:0], wd_ext[31:0]} : wd_ext;
    assign cyc_lo_we = do_write && (i_csr_addr == ADDR_MCYCLE);
    assign cyc_hi_we = do_write && ((i_csr_addr == ADDR_MCYCLEH) ||
                                    ((XLEN == 64) && (i_csr_addr == ADDR_MCYCLE)));
    assign ret_lo_we = do_write && (i_csr_addr == ADDR_MINSTRET);
    assign ret_hi_we = do_write && ((i_csr_addr == ADDR_MINSTRETH) ||
                                    ((XLEN == 64) && (i_csr_addr == ADDR_MINSTRET)));

    generate
        if (HAS_COUNTERS) begin : g_counters
            csr_counter64 u_mcycle (
                .clk    (i_clk),
                .rst    (i_rst),
                .inc_en (1'b1),
                .lo_we  (cyc_lo_we),
                .hi_we  (cyc_hi_we),
                .wdata  (cnt_wdata),
                .count  (mcycle)
            );
            csr_counter64 u_minstret (
                .clk    (i_clk),
                .rst    (i_rst),
                .inc_en (i_retire && !i_trap),
                .lo_we  (ret_lo_we),
                .hi_we  (ret_hi_we),
                .wdata  (cnt_wdata),
                .count  (minstret)
            );
        end else begin : g_no_counters
            assign mcycle   = '0;
            assign minstret = '0;
        end
    endgenerate

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file with trap sequencing.
- Executes csrrw/csrrs/csrrc read-modify-write internally.
- Owns mstatus MIE/MPIE, mtvec direct/vectored modes, mie/mip interrupt gating, mscratch, and 64-bit mcycle/minstret.
- Sits between IDU/EXU (CSR ops), the exception/interrupt logic (trap/mret), and IFU (trap vector and mepc redirect).

Parameters:
- XLEN, 32, data width; legal values are 32 and 64.
- HAS_COUNTERS, 1, set to 0 to remove mcycle/minstret; their addresses then become illegal.
- MTVEC_VECTORED, 1, set to 0 to force mtvec.MODE to read 0 and ignore writes to MODE.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_csr_en  in  1  CSR instruction valid this cycle.
- i_csr_op  in  2  01=RW, 10=RS, 11=RC; 00 is treated as no-op.
- i_csr_addr  in  12  CSR address.
- i_csr_wsrc  in  XLEN  rs1 value or zero-extended uimm.
- i_csr_wzero  in  1  source operand is x0/uimm==0; suppresses the write for RS/RC.
- o_csr_rdata  out  XLEN  old CSR value (combinational).
- o_csr_illegal  out  1  unknown address, or write to a read-only CSR.
- i_trap  in  1  take trap this cycle.
- i_trap_cause  in  XLEN  mcause value; MSB set for interrupt.
- i_trap_pc  in  XLEN  faulting/interrupted PC.
- i_mret  in  1  mret executing.
- i_retire  in  1  one instruction retired.
- i_irq_timer  in  1  level MTIP.
- i_irq_ext  in  1  level MEIP.
- o_irq_pending  out  1  interrupt enabled and pending.
- o_irq_cause  out  XLEN  cause for the highest-priority pending interrupt.
- o_trap_vec  out  XLEN  target PC for the current i_trap_cause.
- o_mepc  out  XLEN  mepc, for mret.

Behaviour:
- Reset values:
  - mstatus = 0x1800 (MPP=M, MIE=0, MPIE=0); mtvec, mepc, mcause, mscratch, mie, mcycle, minstret = 0.
  - o_irq_pending = 0.
- Implemented CSRs: mstatus 0x300, misa 0x301 (RO), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (RO), mcycle 0xB00, minstret 0xB02, mhartid 0xF14 (RO, 0).
  - mcycleh 0xB80 and minstreth 0xB82 exist only when XLEN=32.
- Reads: combinational. o_csr_rdata is 0 when i_csr_en=0 or the address is unimplemented.
- Write value by op: RW writes wsrc; RS writes old|wsrc; RC writes old&~wsrc.
  - RS/RC with i_csr_wzero=1 perform no write and are never illegal on RO CSRs.
  - Write commits at the next edge; same-cycle read returns the old value.
- Illegal access: o_csr_illegal=1 combinationally and no state changes. The illegal op is ignored by the block; the caller raises the trap.
- WARL masks:
  - mstatus: only MIE(3), MPIE(7) writable; MPP reads 2'b11.
  - mepc[1:0] reads 0.
  - mtvec[1] reads 0; mtvec[0] forced to 0 when MTVEC_VECTORED=0.
  - mie: only MTIE(7), MEIE(11) writable.
- Priority in one cycle: i_trap > i_mret > CSR write. A lower-priority action in the same cycle is dropped entirely.
- Trap entry, one edge:
  - mepc <= i_trap_pc & ~3; mcause <= i_trap_cause.
  - MPIE <= MIE; MIE <= 0.
- o_trap_vec, combinational from the current mtvec:
  - mtvec.MODE=1 and i_trap_cause MSB=1 -> {BASE,2'b00} + 4*cause[XLEN-2:0].
  - Otherwise -> {BASE,2'b00}.
- mret, one edge: MIE <= MPIE; MPIE <= 1.
- mip: MTIP = i_irq_timer, MEIP = i_irq_ext, sampled live; no latching.
- Interrupt output:
  - o_irq_pending = MIE & |(mip & mie).
  - o_irq_cause: external (MSB|11) beats timer (MSB|7); 0 when nothing is pending.
- Counters:
  - mcycle +1 every cycle; minstret +1 when i_retire=1 and i_trap=0.
  - Both wrap at 2^64-1 -> 0; the low half carries into the high half.
  - A CSR write to either half loads the written value into that half, keeps the other half, and suppresses the increment that cycle.
- Reset asserted mid-operation overrides trap, mret and CSR write in that cycle.

Decomposition:
- Package csr_pkg holds:
  - CSR address constants;
  - op encodings (CSR_RW/RS/RC);
  - mstatus/mie bit indices;
  - interrupt cause codes;
  - WARL write masks.
- Sub-module csr_counter64 is a 64-bit counter with an increment enable and split low/high write enables.
  - It is instantiated twice (mcycle, minstret).
  - It is omitted when HAS_COUNTERS=0.

Test Plan:
- Reset, then read each CSR -> mstatus=0x1800, all others 0; read 0x7C0 -> rdata=0, illegal=1.
- RW mtvec=0x8000_0101, then trap with cause 0x8000_0007 -> o_trap_vec=0x8000_011C. Same trap with mtvec=0x8000_0100 and cause 2 -> 0x8000_0100.
- MIE=1, trap at pc 0x8000_0042 -> mepc=0x8000_0040, MIE=0, MPIE=1. mret -> MIE=1, MPIE=1.
- Same-cycle i_trap and CSR RW mepc=0x1234 -> mepc=trap pc; mscratch write with i_mret -> mscratch unchanged.
- Write mcycle=0xFFFF_FFFF, mcycleh=0 -> two cycles later mcycleh=1, mcycle=0. A CSR write in the same cycle as i_retire -> minstret holds the written value.
- MIE=1, mie=0x880, timer=1 and ext=1 -> o_irq_pending=1, cause=0x8000_000B. Drop ext -> cause=0x8000_0007. MIE=0 -> pending=0.
